// File: rtl/uart_cfg_sequencer_pkg.sv
// Shared types and constants for the UART configuration sequencer.
// Holds 16550 register offsets, the LCR DLAB mask, FSM states and lane helpers.
package uart_top_package;

    localparam logic [4:0] REG_RBR_THR = 5'd0;
    localparam logic [4:0] REG_DLL     = 5'd0;
    localparam logic [4:0] REG_IER     = 5'd1;
    localparam logic [4:0] REG_DLM     = 5'd1;
    localparam logic [4:0] REG_IIR_FCR = 5'd2;
    localparam logic [4:0] REG_LCR     = 5'd3;
    localparam logic [4:0] REG_MCR     = 5'd4;
    localparam logic [4:0] REG_LSR     = 5'd5;
    localparam logic [4:0] REG_MSR     = 5'd6;
    localparam logic [4:0] REG_SCR     = 5'd7;

    localparam logic [7:0] LCR_DLAB = 8'h80;

    localparam int         N_STEPS   = 6;
    localparam logic [2:0] LAST_STEP = 3'(N_STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_GAP,
        ST_PASS
    } state_e;

    // Byte-wide registers sit on the lane selected by the low address bits.
    function automatic logic [31:0] lane_dat(input logic [1:0] lane,
                                             input logic [7:0] b);
        return {24'h0, b} << {lane, 3'b000};
    endfunction

    function automatic logic [3:0] lane_sel(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/uart_cfg_sequencer_if.sv
// Wishbone-style bus bundle used for the host side and the UART side.
// master drives the request (adr/dat_w/we/sel/stb/cyc), slave returns dat_r/ack.
interface uart_cfg_sequencer_if;
    logic [4:0]  adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc;
    logic        ack;

    modport master (
        output adr, dat_w, we, sel, stb, cyc,
        input  dat_r, ack
    );

    modport slave (
        input  adr, dat_w, we, sel, stb, cyc,
        output dat_r, ack
    );
endinterface

// File: rtl/uart_cfg_step_rom.sv
// Combinational table of the six UART configuration writes.
// Ports: step_i step index in, adr_o register byte address, dat_o register byte.
module uart_cfg_step_rom
    import uart_top_package::*;
#(
    parameter logic [15:0] DIV     = 16'd27,
    parameter logic [7:0]  LCR_VAL = 8'h03,
    parameter logic [7:0]  FCR_VAL = 8'hC7,
    parameter logic [7:0]  IER_VAL = 8'h01
) (
    input  logic [2:0] step_i,
    output logic [4:0] adr_o,
    output logic [7:0] dat_o
);

    always_comb begin
        adr_o = REG_RBR_THR;
        dat_o = 8'h00;
        unique case (step_i)
            3'd0: begin
                adr_o = REG_LCR;
                dat_o = LCR_VAL | LCR_DLAB;
            end
            3'd1: begin
                adr_o = REG_DLL;
                dat_o = DIV[7:0];
            end
            3'd2: begin
                adr_o = REG_DLM;
                dat_o = DIV[15:8];
            end
            3'd3: begin
                adr_o = REG_LCR;
                dat_o = LCR_VAL & ~LCR_DLAB;
            end
            3'd4: begin
                adr_o = REG_IIR_FCR;
                dat_o = FCR_VAL;
            end
            3'd5: begin
                adr_o = REG_IER;
                dat_o = IER_VAL;
            end
            default: begin
                adr_o = REG_RBR_THR;
                dat_o = 8'h00;
            end
        endcase
    end

endmodule

// File: rtl/uart_cfg_sequencer.sv
// Programs a 16550-style UART after reset or start_i, then passes host bus through.
// Ports: clk_i/rst_i, start_i, host wbs_* slave side, UART wbm_* master side, busy/done/err.
module uart_cfg_sequencer
    import uart_top_package::*;
#(
    parameter logic [15:0] DIV     = 16'd27,
    parameter logic [7:0]  LCR_VAL = 8'h03,
    parameter logic [7:0]  FCR_VAL = 8'hC7,
    parameter logic [7:0]  IER_VAL = 8'h01,
    parameter logic [7:0]  TIMEOUT = 8'd255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [4:0]  wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    output logic        wbs_ack_o,
    output logic [4:0]  wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    input  logic        wbm_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    state_e     state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic [4:0] rom_adr;
    logic [7:0] rom_dat;

    uart_cfg_step_rom #(
        .DIV     (DIV),
        .LCR_VAL (LCR_VAL),
        .FCR_VAL (FCR_VAL),
        .IER_VAL (IER_VAL)
    ) u_rom (
        .step_i (step_q),
        .adr_o  (rom_adr),
        .dat_o  (rom_dat)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            step_q  <= 3'd0;
            cnt_q   <= 8'd0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        done_d    = done_q;
        err_d     = err_q;
        wbm_adr_o = 5'd0;
        wbm_dat_o = 32'd0;
        wbm_we_o  = 1'b0;
        wbm_sel_o = 4'd0;
        wbm_stb_o = 1'b0;
        wbm_cyc_o = 1'b0;
        wbs_ack_o = 1'b0;
        wbs_dat_o = 32'd0;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_BUS;
                step_d  = 3'd0;
                cnt_d   = 8'd0;
            end
            ST_BUS: begin
                wbm_adr_o = rom_adr;
                wbm_dat_o = lane_dat(rom_adr[1:0], rom_dat);
                wbm_sel_o = lane_sel(rom_adr[1:0]);
                wbm_we_o  = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_cyc_o = 1'b1;
                if (wbm_ack_i) begin
                    state_d = ST_GAP;
                end else if ({1'b0, cnt_q} + 9'd1 >= {1'b0, TIMEOUT}) begin
                    // Abort: leave done clear so software sees only err.
                    state_d = ST_PASS;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_GAP: begin
                if (step_q == LAST_STEP) begin
                    state_d = ST_PASS;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_BUS;
                    step_d  = step_q + 3'd1;
                    cnt_d   = 8'd0;
                end
            end
            ST_PASS: begin
                wbm_adr_o = wbs_adr_i;
                wbm_dat_o = wbs_dat_i;
                wbm_we_o  = wbs_we_i;
                wbm_sel_o = wbs_sel_i;
                wbm_stb_o = wbs_stb_i;
                wbm_cyc_o = wbs_cyc_i;
                wbs_ack_o = wbm_ack_i;
                wbs_dat_o = wbm_dat_i;
                // Never cut an open host cycle; remember the request instead.
                if (start_i || pend_q) begin
                    if (!wbs_cyc_i) begin
                        state_d = ST_BUS;
                        step_d  = 3'd0;
                        cnt_d   = 8'd0;
                        pend_d  = 1'b0;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o = (state_q != ST_PASS);
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_uart_cfg_sequencer.sv
// Self-checking bench for uart_cfg_sequencer with a randomized UART slave.
// Expected writes and timings come from a table built from the register rules.
module tb_uart_cfg_sequencer;

    localparam logic [15:0] DIV     = 16'd27;
    localparam logic [7:0]  LCR_VAL = 8'h03;
    localparam logic [7:0]  FCR_VAL = 8'hC7;
    localparam logic [7:0]  IER_VAL = 8'h01;
    localparam logic [7:0]  TIMEOUT = 8'd8;

    logic clk_i = 1'b0;
    logic rst_i;
    logic start_i;
    logic busy_o;
    logic done_o;
    logic err_o;

    uart_cfg_sequencer_if hb();
    uart_cfg_sequencer_if ub();

    int tests = 0;
    int fails = 0;
    int exp_adr [6];
    int exp_byte [6];

    always #5 clk_i = ~clk_i;

    uart_cfg_sequencer #(
        .DIV     (DIV),
        .LCR_VAL (LCR_VAL),
        .FCR_VAL (FCR_VAL),
        .IER_VAL (IER_VAL),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .wbs_adr_i (hb.adr),
        .wbs_dat_i (hb.dat_w),
        .wbs_dat_o (hb.dat_r),
        .wbs_we_i  (hb.we),
        .wbs_sel_i (hb.sel),
        .wbs_stb_i (hb.stb),
        .wbs_cyc_i (hb.cyc),
        .wbs_ack_o (hb.ack),
        .wbm_adr_o (ub.adr),
        .wbm_dat_o (ub.dat_w),
        .wbm_dat_i (ub.dat_r),
        .wbm_we_o  (ub.we),
        .wbm_sel_o (ub.sel),
        .wbm_stb_o (ub.stb),
        .wbm_cyc_o (ub.cyc),
        .wbm_ack_i (ub.ack),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    task automatic chk(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_dat(input int s);
        longint v;
        v = longint'(exp_byte[s]) * (longint'(1) << (8 * (exp_adr[s] % 4)));
        return 32'(v);
    endfunction

    function automatic logic [3:0] exp_sel(input int s);
        return 4'(1 << (exp_adr[s] % 4));
    endfunction

    function automatic int pick_lat(input int max_lat);
        if (max_lat < 0) return 1;
        return int'($urandom_range(max_lat, 0));
    endfunction

    task automatic chk_reset(input string tag);
        chk(tag, {busy_o, done_o, err_o, ub.stb, ub.cyc, ub.we, ub.sel,
                  ub.adr, ub.dat_w, hb.ack, hb.dat_r},
            {3'b100, 3'b000, 4'h0, 5'h0, 32'h0, 1'b0, 32'h0});
    endtask

    task automatic host_xfer(input logic [4:0] a, input logic [31:0] d,
                             input logic we, input logic [3:0] s);
        logic [31:0] rd;
        rd = $urandom;
        hb.adr = a; hb.dat_w = d; hb.we = we; hb.sel = s;
        hb.cyc = 1'b1; hb.stb = 1'b1;
        ub.ack = 1'b0; ub.dat_r = rd;
        #1;
        chk("pass_req", {busy_o, ub.cyc, ub.stb, ub.we, ub.sel, ub.adr,
                         ub.dat_w, hb.ack},
            {1'b0, 2'b11, we, s, a, d, 1'b0});
        @(posedge clk_i); #1;
        ub.ack = 1'b1;
        #1;
        chk("pass_rsp", {hb.ack, hb.dat_r}, {1'b1, rd});
        @(posedge clk_i); #1;
        hb.cyc = 1'b0; hb.stb = 1'b0; hb.we = 1'b0; ub.ack = 1'b0;
    endtask

    // UART slave + checker for one configuration run.
    // dead_step: step never acked; rst_step: step at which reset is pulsed.
    task automatic run_seq(input int max_lat, input int dead_step,
                           input int rst_step, input bit host_req,
                           output int start_lat, output int total);
        int step, wait_c, lat, cyc, t0, td, exp_cyc;
        bit started, fin;
        step = 0; wait_c = 0; cyc = 0; t0 = 0; td = 0; exp_cyc = 0;
        started = 1'b0; fin = 1'b0; start_lat = -1; total = -1;
        lat = pick_lat(max_lat);
        while (!fin && cyc < 400) begin
            @(posedge clk_i); #1;
            cyc++;
            if (!started && ub.stb) begin
                started = 1'b1; start_lat = cyc; t0 = cyc;
                chk("step0_flags", {busy_o, done_o, err_o}, 3'b100);
                if (host_req) begin
                    hb.cyc = 1'b1; hb.stb = 1'b1; hb.we = 1'b1;
                    hb.adr = 5'd7; hb.sel = 4'($urandom);
                    hb.dat_w = $urandom;
                end
            end
            if (!started) begin
                start_i = 1'b0;
                ub.ack = 1'($urandom);
            end else if (!busy_o) begin
                fin = 1'b1;
                total = cyc - t0;
            end else begin
                chk("host_stall", {hb.ack, hb.dat_r}, 33'h0);
                start_i = 1'($urandom);
                ub.dat_r = $urandom;
                if (ub.stb) begin
                    chk("wr_step", {ub.cyc, ub.we, ub.adr, ub.sel, ub.dat_w},
                        {2'b11, 5'(exp_adr[step]), exp_sel(step),
                         exp_dat(step)});
                    if (wait_c == 0 && step == dead_step) td = cyc;
                    if (step == rst_step) begin
                        rst_i = 1'b1; start_i = 1'b0; ub.ack = 1'b0;
                        @(posedge clk_i); #1;
                        chk_reset("rst_mid");
                        rst_i = 1'b0; ub.ack = 1'b1;
                        fin = 1'b1;
                    end else if (step != dead_step && wait_c == lat) begin
                        ub.ack = 1'b1;
                        exp_cyc += 2 + lat;
                        step++;
                        wait_c = 0;
                        lat = pick_lat(max_lat);
                    end else begin
                        ub.ack = 1'b0;
                        wait_c++;
                    end
                end else begin
                    chk("gap_quiet", {ub.cyc, ub.we, ub.sel}, 6'h0);
                    ub.ack = 1'($urandom);
                end
            end
        end
        start_i = 1'b0;
        ub.ack = 1'b0;
        if (!fin) begin
            chk("seq_bound", 96'(fin), 96'd1);
        end else if (rst_step >= 6 && dead_step < 6) begin
            chk("timeout", {err_o, done_o, 8'(cyc - td)}, {2'b10, TIMEOUT});
        end else if (rst_step >= 6) begin
            chk("done_flags", {done_o, err_o}, 2'b10);
            chk("seq_len", 96'(total), 96'(exp_cyc));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sl;
        int tot;
        int k;

        exp_adr  = '{3, 0, 1, 3, 2, 1};
        exp_byte[0] = int'(LCR_VAL | 8'h80);
        exp_byte[1] = int'(DIV) % 256;
        exp_byte[2] = int'(DIV) / 256;
        exp_byte[3] = int'(LCR_VAL) % 128;
        exp_byte[4] = int'(FCR_VAL);
        exp_byte[5] = int'(IER_VAL);

        rst_i = 1'b1; start_i = 1'b0;
        hb.adr = 5'd0; hb.dat_w = 32'd0; hb.we = 1'b0; hb.sel = 4'd0;
        hb.stb = 1'b0; hb.cyc = 1'b0;
        ub.ack = 1'b0; ub.dat_r = 32'd0;
        repeat (3) @(posedge clk_i);
        #1;
        chk_reset("reset");

        // Release with a spurious ack that must be ignored in idle.
        ub.ack = 1'b1;
        rst_i = 1'b0;
        run_seq(-1, 6, 6, 1'b0, sl, tot);
        chk("rel_lat", 96'(sl), 96'd1);
        chk("seq18", 96'(tot), 96'd18);
        repeat (3) @(posedge clk_i);
        #1;
        chk("no_restart", {busy_o, done_o}, 2'b01);

        for (int i = 0; i < 6; i++)
            host_xfer(5'($urandom), $urandom, 1'($urandom), 4'($urandom));

        // Host write raised mid-sequence stalls until done.
        start_i = 1'b1;
        run_seq(2, 6, 6, 1'b1, sl, tot);
        chk("start_lat", 96'(sl), 96'd1);
        #1;
        chk("held_req", {ub.cyc, ub.stb, ub.we, ub.adr, ub.sel, ub.dat_w,
                         hb.ack},
            {3'b111, hb.adr, hb.sel, hb.dat_w, 1'b0});
        ub.ack = 1'b1;
        #1;
        chk("held_ack", 96'(hb.ack), 96'd1);
        @(posedge clk_i); #1;
        hb.cyc = 1'b0; hb.stb = 1'b0; hb.we = 1'b0; ub.ack = 1'b0;

        // start_i during an open host cycle is deferred.
        hb.cyc = 1'b1; hb.stb = 1'b1; hb.we = 1'b0; hb.adr = 5'd4;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        k = int'($urandom_range(5, 2));
        for (int i = 0; i < k; i++) begin
            chk("pend_hold", {busy_o, done_o, ub.stb, ub.adr}, {3'b011, 5'd4});
            @(posedge clk_i); #1;
        end
        hb.cyc = 1'b0; hb.stb = 1'b0;
        run_seq(3, 6, 6, 1'b0, sl, tot);
        chk("pend_lat", 96'(sl), 96'd1);

        // Step 2 never acked: timeout, then pass-through still works.
        start_i = 1'b1;
        run_seq(1, 2, 6, 1'b0, sl, tot);
        host_xfer(5'd5, 32'h0, 1'b0, 4'b0010);

        // Reset pulsed during step 3, then full replay from step 0.
        start_i = 1'b1;
        run_seq(2, 6, 3, 1'b0, sl, tot);
        run_seq(2, 6, 6, 1'b0, sl, tot);
        chk("rst_restart_lat", 96'(sl), 96'd1);

        for (int i = 0; i < 3; i++) begin
            start_i = 1'b1;
            run_seq(3, 6, 6, 1'b0, sl, tot);
            host_xfer(5'($urandom), $urandom, 1'($urandom), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
